branch_resolver: RTL

In-order branch resolution buffer for the out-of-order core; it is the producer of the branch-forwarding interface consumed by the PC/predictor. Fetch allocates one entry per conditional branch with its prediction. The branch ALU resolves entries out of order by tag. The block retires entries in program order, emitting taken/pc/correct-address to train the predictor, and raises misbranch (then self-flushes) when the prediction was wrong.

---
 rtl/branch_resolver.sv | 123 ++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// In-order branch resolution buffer: fetch allocates, the branch ALU resolves out of order,
// entries retire in program order and a mispredicted retire flushes the whole buffer.
module branch_resolver #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_alloc_valid,
    input  logic [31:0]      in_alloc_pc,
    input  logic             in_alloc_pred_taken,
    input  logic [31:0]      in_alloc_pred_target,
    output logic [TAG_W-1:0] out_alloc_tag,
    output logic             out_full,
    input  logic             in_res_valid,
    input  logic [TAG_W-1:0] in_res_tag,
    input  logic             in_res_taken,
    input  logic [31:0]      in_res_target,
    output logic             out_branch_valid,
    output logic             out_branch_taken,
    output logic [31:0]      out_branch_pc,
    output logic [31:0]      out_correct_address,
    output logic             out_misbranch
);

    localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   CNT_ONE    = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);

    logic             valid_r       [DEPTH];
    logic             done_r        [DEPTH];
    logic [31:0]      pc_r          [DEPTH];
    logic [31:0]      pred_target_r [DEPTH];
    logic             taken_r       [DEPTH];
    logic [31:0]      corr_r        [DEPTH];
    logic [TAG_W-1:0] head_r;
    logic [TAG_W-1:0] tail_r;
    logic [TAG_W:0]   count_r;

    logic full_s;
    logic retire_s;
    logic mis_s;
    logic alloc_s;
    logic res_s;
    logic unused_pred_taken_s;

    // The misbranch decision compares addresses only, so the taken bit of the prediction is redundant.
    assign unused_pred_taken_s = in_alloc_pred_taken;

    assign full_s        = (count_r == FULL_COUNT);
    assign out_full      = full_s;
    assign out_alloc_tag = tail_r;

    // A mispredicted retire doubles as the flush and suppresses same-edge allocate/resolve.
    assign retire_s = ena && valid_r[head_r] && done_r[head_r];
    assign mis_s    = retire_s && (corr_r[head_r] != pred_target_r[head_r]);
    assign alloc_s  = ena && in_alloc_valid && !full_s && !mis_s;
    assign res_s    = ena && in_res_valid && valid_r[in_res_tag] && !done_r[in_res_tag] && !mis_s;

    // Entry storage, pointers, occupancy and registered retire outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i]       <= 1'b0;
                done_r[i]        <= 1'b0;
                pc_r[i]          <= 32'd0;
                pred_target_r[i] <= 32'd0;
                taken_r[i]       <= 1'b0;
                corr_r[i]        <= 32'd0;
            end
            head_r              <= '0;
            tail_r              <= '0;
            count_r             <= '0;
            out_branch_valid    <= 1'b0;
            out_branch_taken    <= 1'b0;
            out_branch_pc       <= 32'd0;
            out_correct_address <= 32'd0;
            out_misbranch       <= 1'b0;
        end else begin
            out_branch_valid <= retire_s;
            out_misbranch    <= mis_s;
            if (retire_s) begin
                out_branch_taken    <= taken_r[head_r];
                out_branch_pc       <= pc_r[head_r];
                out_correct_address <= corr_r[head_r];
            end

            if (mis_s) begin
                for (int i = 0; i < DEPTH; i++) begin
                    valid_r[i] <= 1'b0;
                end
                head_r  <= '0;
                tail_r  <= '0;
                count_r <= '0;
            end else begin
                if (alloc_s) begin
                    valid_r[tail_r]       <= 1'b1;
                    done_r[tail_r]        <= 1'b0;
                    pc_r[tail_r]          <= in_alloc_pc;
                    pred_target_r[tail_r] <= in_alloc_pred_target;
                    tail_r                <= tail_r + TAG_ONE;
                end
                if (res_s) begin
                    done_r[in_res_tag]  <= 1'b1;
                    taken_r[in_res_tag] <= in_res_taken;
                    corr_r[in_res_tag]  <= in_res_taken ? in_res_target
                                                        : pc_r[in_res_tag] + 32'd4;
                end
                if (retire_s) begin
                    valid_r[head_r] <= 1'b0;
                    head_r          <= head_r + TAG_ONE;
                end
                case ({alloc_s, retire_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule
